// File: rtl/execute_stage_md.sv
`default_nettype none
// ============================================================================
// execute_stage_md : EX stage - forwarding, ALU, branch adder, iterative MD unit
// Revision 1.0
// ============================================================================
module execute_stage_md #(
    parameter int DW    = 32,
    parameter int RW    = 5,
    parameter int MD_EN = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [1:0]    in_wb,
    input  logic [2:0]    in_mem,
    input  logic [3:0]    in_alu_sel,
    input  logic          in_use_imm,
    input  logic          in_dst_rd,
    input  logic [1:0]    in_md_op,
    input  logic [DW-1:0] in_pc,
    input  logic [DW-1:0] in_rega,
    input  logic [DW-1:0] in_regb,
    input  logic [DW-1:0] in_imm,
    input  logic [RW-1:0] in_rs,
    input  logic [RW-1:0] in_rt,
    input  logic [RW-1:0] in_rd,
    input  logic [DW-1:0] mem_result,
    input  logic [RW-1:0] mem_rd,
    input  logic          mem_regf_wr,
    input  logic [DW-1:0] wb_wd,
    input  logic [RW-1:0] wb_rd,
    input  logic          wb_regf_wr,
    output logic          stall,
    output logic          out_valid,
    output logic [1:0]    out_wb,
    output logic [2:0]    out_mem,
    output logic [DW-1:0] out_pcjump,
    output logic [DW-1:0] out_result,
    output logic          out_zero,
    output logic [DW-1:0] out_regb,
    output logic [RW-1:0] out_wreg
);
    localparam int SW = $clog2(DW);
    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] mx_q, mx_d;
    logic [DW-1:0] my_q, my_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [1:0]    op_q, op_d;
    logic [1:0]    cwb_q, cwb_d;
    logic [2:0]    cmem_q, cmem_d;
    logic [RW-1:0] cwreg_q, cwreg_d;
    logic [DW-1:0] cpcj_q, cpcj_d;
    logic [DW-1:0] cregb_q, cregb_d;

    logic          valid_q, valid_d;
    logic [1:0]    wb_q, wb_d;
    logic [2:0]    mem_q, mem_d;
    logic [DW-1:0] pcj_q, pcj_d;
    logic [DW-1:0] result_q, result_d;
    logic          zero_q, zero_d;
    logic [DW-1:0] regb_q, regb_d;
    logic [RW-1:0] wreg_q, wreg_d;

    logic [DW-1:0] fwd_a, fwd_b, op_b, alu_res, pcjump, md_res, div_diff;
    logic [SW-1:0] shamt;
    logic [RW-1:0] dst;
    logic [DW:0]   rem_sh;
    logic          div_fits;
    logic          md_start;

    // Register 0 is hard-wired, so it is never a forwarding target.
    always_comb begin
        fwd_a = in_rega;
        if (mem_regf_wr && (mem_rd == in_rs) && (in_rs != '0))
            fwd_a = mem_result;
        else if (wb_regf_wr && (wb_rd == in_rs) && (in_rs != '0))
            fwd_a = wb_wd;
        fwd_b = in_regb;
        if (mem_regf_wr && (mem_rd == in_rt) && (in_rt != '0))
            fwd_b = mem_result;
        else if (wb_regf_wr && (wb_rd == in_rt) && (in_rt != '0))
            fwd_b = wb_wd;
    end

    assign op_b   = in_use_imm ? in_imm : fwd_b;
    assign shamt  = op_b[SW-1:0];
    assign pcjump = in_pc + (in_imm << 2);
    assign dst    = in_dst_rd ? in_rd : in_rt;

    always_comb begin
        alu_res = '0;
        case (in_alu_sel)
            4'h0:    alu_res = fwd_a + op_b;
            4'h1:    alu_res = fwd_a - op_b;
            4'h2:    alu_res = fwd_a & op_b;
            4'h3:    alu_res = fwd_a | op_b;
            4'h4:    alu_res = fwd_a ^ op_b;
            4'h5:    alu_res = ~(fwd_a | op_b);
            4'h6:    alu_res = {{(DW-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
            4'h7:    alu_res = {{(DW-1){1'b0}}, (fwd_a < op_b)};
            4'h8:    alu_res = fwd_a << shamt;
            4'h9:    alu_res = fwd_a >> shamt;
            4'hA:    alu_res = $unsigned($signed(fwd_a) >>> shamt);
            4'hB:    alu_res = in_imm << 16;
            default: alu_res = '0;
        endcase
    end

    assign md_start = (MD_EN != 0) && (state_q == ST_IDLE) && in_valid && (in_md_op != 2'b00);
    assign stall    = md_start || (state_q == ST_BUSY);

    // Restoring-division step: remainder shifts in the next dividend bit (mx MSB).
    assign rem_sh   = {acc_q, mx_q[DW-1]};
    assign div_fits = (rem_sh >= {1'b0, my_q});
    assign div_diff = rem_sh[DW-1:0] - my_q;
    assign md_res   = (op_q == 2'b10) ? mx_q : acc_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mx_d     = mx_q;
        my_d     = my_q;
        acc_d    = acc_q;
        op_d     = op_q;
        cwb_d    = cwb_q;
        cmem_d   = cmem_q;
        cwreg_d  = cwreg_q;
        cpcj_d   = cpcj_q;
        cregb_d  = cregb_q;
        valid_d  = 1'b0;
        wb_d     = 2'b00;
        mem_d    = 3'b010;
        pcj_d    = '0;
        result_d = '0;
        zero_d   = 1'b0;
        regb_d   = '0;
        wreg_d   = '0;
        case (state_q)
            ST_IDLE: begin
                if (md_start) begin
                    state_d = ST_BUSY;
                    cnt_d   = CW'(DW);
                    op_d    = in_md_op;
                    acc_d   = '0;
                    // MUL walks the multiplier (B) LSB-first; DIV walks the dividend (A) MSB-first.
                    if (in_md_op == 2'b01) begin
                        mx_d = op_b;
                        my_d = fwd_a;
                    end else begin
                        mx_d = fwd_a;
                        my_d = op_b;
                    end
                    cwb_d   = in_wb;
                    cmem_d  = in_mem;
                    cwreg_d = dst;
                    cpcj_d  = pcjump;
                    cregb_d = fwd_b;
                end else if (in_valid) begin
                    valid_d  = 1'b1;
                    wb_d     = in_wb;
                    mem_d    = in_mem;
                    pcj_d    = pcjump;
                    result_d = alu_res;
                    zero_d   = (alu_res == '0);
                    regb_d   = fwd_b;
                    wreg_d   = dst;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (op_q == 2'b01) begin
                    acc_d = acc_q + (mx_q[0] ? my_q : '0);
                    mx_d  = mx_q >> 1;
                    my_d  = my_q << 1;
                end else if (div_fits) begin
                    acc_d = div_diff;
                    mx_d  = {mx_q[DW-2:0], 1'b1};
                end else begin
                    acc_d = rem_sh[DW-1:0];
                    mx_d  = {mx_q[DW-2:0], 1'b0};
                end
                if (cnt_q == CW'(1))
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d  = ST_IDLE;
                valid_d  = 1'b1;
                wb_d     = cwb_q;
                mem_d    = cmem_q;
                pcj_d    = cpcj_q;
                result_d = md_res;
                zero_d   = (md_res == '0);
                regb_d   = cregb_q;
                wreg_d   = cwreg_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mx_q     <= '0;
            my_q     <= '0;
            acc_q    <= '0;
            op_q     <= 2'b00;
            cwb_q    <= 2'b00;
            cmem_q   <= 3'b010;
            cwreg_q  <= '0;
            cpcj_q   <= '0;
            cregb_q  <= '0;
            valid_q  <= 1'b0;
            wb_q     <= 2'b00;
            mem_q    <= 3'b010;
            pcj_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            regb_q   <= '0;
            wreg_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mx_q     <= mx_d;
            my_q     <= my_d;
            acc_q    <= acc_d;
            op_q     <= op_d;
            cwb_q    <= cwb_d;
            cmem_q   <= cmem_d;
            cwreg_q  <= cwreg_d;
            cpcj_q   <= cpcj_d;
            cregb_q  <= cregb_d;
            valid_q  <= valid_d;
            wb_q     <= wb_d;
            mem_q    <= mem_d;
            pcj_q    <= pcj_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            regb_q   <= regb_d;
            wreg_q   <= wreg_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_wb     = wb_q;
    assign out_mem    = mem_q;
    assign out_pcjump = pcj_q;
    assign out_result = result_q;
    assign out_zero   = zero_q;
    assign out_regb   = regb_q;
    assign out_wreg   = wreg_q;

endmodule
`default_nettype wire

// File: tb/tb_execute_stage_md.sv
`default_nettype none
// ============================================================================
// tb_execute_stage_md : randomized self-checking bench against a behavioural model
// Revision 1.0
// ============================================================================
module tb_execute_stage_md;
    localparam int DW = 32;
    localparam int RW = 5;
    localparam logic [107:0] RST_VEC = {1'b0, 2'b00, 3'b010, 102'b0};

    logic          clk = 1'b1;
    logic          rst_n;
    logic          in_valid, in_use_imm, in_dst_rd;
    logic [1:0]    in_wb, in_md_op;
    logic [2:0]    in_mem;
    logic [3:0]    in_alu_sel;
    logic [DW-1:0] in_pc, in_rega, in_regb, in_imm, mem_result, wb_wd;
    logic [RW-1:0] in_rs, in_rt, in_rd, mem_rd, wb_rd;
    logic          mem_regf_wr, wb_regf_wr;

    logic          stall, out_valid, out_zero;
    logic [1:0]    out_wb;
    logic [2:0]    out_mem;
    logic [DW-1:0] out_pcjump, out_result, out_regb;
    logic [RW-1:0] out_wreg;

    logic          stall0, out_valid0, out_zero0;
    logic [1:0]    out_wb0;
    logic [2:0]    out_mem0;
    logic [DW-1:0] out_pcjump0, out_result0, out_regb0;
    logic [RW-1:0] out_wreg0;

    logic [107:0]  act_vec, act0_vec;
    assign act_vec  = {out_valid, out_wb, out_mem, out_result, out_zero, out_regb, out_wreg, out_pcjump};
    assign act0_vec = {out_valid0, out_wb0, out_mem0, out_result0, out_zero0, out_regb0, out_wreg0, out_pcjump0};

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    execute_stage_md #(.DW(DW), .RW(RW), .MD_EN(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_wb(in_wb), .in_mem(in_mem),
        .in_alu_sel(in_alu_sel), .in_use_imm(in_use_imm), .in_dst_rd(in_dst_rd),
        .in_md_op(in_md_op), .in_pc(in_pc), .in_rega(in_rega), .in_regb(in_regb),
        .in_imm(in_imm), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .mem_result(mem_result), .mem_rd(mem_rd), .mem_regf_wr(mem_regf_wr),
        .wb_wd(wb_wd), .wb_rd(wb_rd), .wb_regf_wr(wb_regf_wr), .stall(stall),
        .out_valid(out_valid), .out_wb(out_wb), .out_mem(out_mem), .out_pcjump(out_pcjump),
        .out_result(out_result), .out_zero(out_zero), .out_regb(out_regb), .out_wreg(out_wreg)
    );

    execute_stage_md #(.DW(DW), .RW(RW), .MD_EN(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_wb(in_wb), .in_mem(in_mem),
        .in_alu_sel(in_alu_sel), .in_use_imm(in_use_imm), .in_dst_rd(in_dst_rd),
        .in_md_op(in_md_op), .in_pc(in_pc), .in_rega(in_rega), .in_regb(in_regb),
        .in_imm(in_imm), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .mem_result(mem_result), .mem_rd(mem_rd), .mem_regf_wr(mem_regf_wr),
        .wb_wd(wb_wd), .wb_rd(wb_rd), .wb_regf_wr(wb_regf_wr), .stall(stall0),
        .out_valid(out_valid0), .out_wb(out_wb0), .out_mem(out_mem0), .out_pcjump(out_pcjump0),
        .out_result(out_result0), .out_zero(out_zero0), .out_regb(out_regb0), .out_wreg(out_wreg0)
    );

    // ---------------- reference model ----------------
    function automatic logic [DW-1:0] fwd_ref(input logic [RW-1:0] src, input logic [DW-1:0] rf);
        if (src == 0) return rf;
        if (mem_regf_wr && mem_rd == src) return mem_result;
        if (wb_regf_wr && wb_rd == src) return wb_wd;
        return rf;
    endfunction

    function automatic logic [DW-1:0] alu_ref(input logic [3:0] sel, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b, input logic [DW-1:0] imm);
        int sh;
        sh = int'(b % 32);
        case (sel)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ~(a | b);
            4'd6:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            4'd7:  return (a < b) ? 32'd1 : 32'd0;
            4'd8:  return a << sh;
            4'd9:  return a >> sh;
            4'd10: return a[31] ? ~((~a) >> sh) : (a >> sh);
            4'd11: return imm * 32'd65536;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [DW-1:0] md_ref(input logic [1:0] op, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (op)
            2'd1:    return p[31:0];
            2'd2:    return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Expected EX/MEM contents for the ALU path given the current inputs.
    function automatic logic [107:0] exp_alu_vec();
        logic [DW-1:0] a, bf, b, r;
        a  = fwd_ref(in_rs, in_rega);
        bf = fwd_ref(in_rt, in_regb);
        b  = in_use_imm ? in_imm : bf;
        r  = alu_ref(in_alu_sel, a, b, in_imm);
        return {1'b1, in_wb, in_mem, r, (r == 0), bf, (in_dst_rd ? in_rd : in_rt), in_pc + in_imm * 4};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic clear_inputs();
        in_valid = 0; in_wb = 0; in_mem = 0; in_alu_sel = 0; in_use_imm = 0; in_dst_rd = 0;
        in_md_op = 0; in_pc = 0; in_rega = 0; in_regb = 0; in_imm = 0;
        in_rs = 0; in_rt = 0; in_rd = 0;
        mem_result = 0; mem_rd = 0; mem_regf_wr = 0; wb_wd = 0; wb_rd = 0; wb_regf_wr = 0;
    endtask

    task automatic rand_alu(input bit fwd);
        in_valid   = 1;
        in_wb      = 2'($urandom);
        in_mem     = 3'($urandom);
        in_alu_sel = 4'($urandom_range(0, 11));
        in_use_imm = 1'($urandom);
        in_dst_rd  = 1'($urandom);
        in_md_op   = 0;
        in_pc      = $urandom;
        in_rega    = $urandom;
        in_regb    = ($urandom_range(0, 3) == 0) ? in_rega : $urandom;
        in_imm     = ($urandom_range(0, 1) == 0) ? 32'($signed(16'($urandom))) : $urandom;
        in_rd      = 5'($urandom);
        mem_result = $urandom;
        wb_wd      = $urandom;
        if (fwd) begin
            in_rs = 5'($urandom_range(0, 3)); in_rt = 5'($urandom_range(0, 3));
            mem_rd = 5'($urandom_range(0, 3)); wb_rd = 5'($urandom_range(0, 3));
            mem_regf_wr = 1'($urandom); wb_regf_wr = 1'($urandom);
        end else begin
            in_rs = 5'($urandom); in_rt = 5'($urandom);
            mem_rd = 0; wb_rd = 0; mem_regf_wr = 0; wb_regf_wr = 0;
        end
    endtask

    // Runs one MD op in dut (and the same inputs through dut0); leaves the inputs applied.
    task automatic run_md(input string name, input logic [1:0] op, input logic [DW-1:0] a,
                          input logic [DW-1:0] b);
        logic [DW-1:0]  pc, imm, exp;
        logic [107:0]   exp0;
        int n, badbub;
        pc = $urandom; imm = $urandom;
        in_valid = 1; in_md_op = op; in_alu_sel = 4'($urandom_range(0, 11));
        in_use_imm = 0; in_dst_rd = 1; in_rs = 5'd1; in_rt = 5'd2; in_rd = 5'd7;
        in_wb = 2'b11; in_mem = 3'b101; in_pc = pc; in_imm = imm; in_rega = a; in_regb = b;
        mem_regf_wr = 0; wb_regf_wr = 0;
        exp  = md_ref(op, a, b);
        exp0 = exp_alu_vec();
        n = 0; badbub = 0;
        @(posedge clk);
        total++;
        if (stall0 !== 1'b0) begin bad++; $display("FAIL %s md_en0_stall got=%b exp=0", name, stall0); end
        while (stall === 1'b1 && n < 100) begin
            n++;
            @(negedge clk); #1;
            if (n == 1) begin
                total++;
                if (act0_vec !== exp0) begin
                    bad++; $display("FAIL %s md_en0_alu got=%h exp=%h", name, act0_vec, exp0);
                end
            end
            if ({out_valid, out_wb, out_mem} !== {1'b0, 2'b00, 3'b010}) badbub++;
            @(posedge clk);
        end
        total++;
        if (n != DW + 1) begin bad++; $display("FAIL %s stall_cycles got=%0d exp=%0d", name, n, DW + 1); end
        total++;
        if (badbub != 0) begin bad++; $display("FAIL %s bubbles got=%0d bad exp=0", name, badbub); end
        @(negedge clk); #1;
        total++;
        if (act_vec !== {1'b1, 2'b11, 3'b101, exp, (exp == 0), b, 5'd7, pc + imm * 4}) begin
            bad++;
            $display("FAIL %s md_result got=%h exp=%h", name, act_vec,
                     {1'b1, 2'b11, 3'b101, exp, (exp == 0), b, 5'd7, pc + imm * 4});
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        repeat (2) @(posedge clk);
        total++;
        if (act_vec !== RST_VEC) begin bad++; $display("FAIL reset_outputs got=%h exp=%h", act_vec, RST_VEC); end
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
        rst_n = 1;
        @(negedge clk); #1;
    endtask

    task automatic test_forward_directed();
        clear_inputs();
        in_valid = 1; in_alu_sel = 0; in_rs = 3; in_rt = 4; in_rega = 32'd100; in_regb = 32'd2;
        mem_rd = 3; mem_regf_wr = 1; mem_result = 32'd5; wb_rd = 3; wb_regf_wr = 1; wb_wd = 32'd9;
        @(negedge clk); #1;
        total++;
        if (out_result !== 32'd7 || out_valid !== 1'b1) begin
            bad++; $display("FAIL fwd_mem_wins got=%0d/%b exp=7/1", out_result, out_valid);
        end
        clear_inputs();
        in_valid = 1; in_alu_sel = 0; in_rs = 0; in_rega = 0; in_use_imm = 1; in_imm = 32'd1;
        mem_rd = 0; mem_regf_wr = 1; mem_result = 32'hFF; wb_rd = 0; wb_regf_wr = 1; wb_wd = 32'h77;
        @(negedge clk); #1;
        total++;
        if (out_result !== 32'd1) begin bad++; $display("FAIL fwd_reg0 got=%0d exp=1", out_result); end
    endtask

    task automatic test_alu_random(input bit fwd, input int iters);
        logic [107:0] exp;
        for (int i = 0; i < iters; i++) begin
            rand_alu(fwd);
            exp = exp_alu_vec();
            @(negedge clk); #1;
            total++;
            if (act_vec !== exp) begin
                bad++;
                $display("FAIL alu_%s[%0d] sel=%0d got=%h exp=%h", fwd ? "fwd" : "plain", i, in_alu_sel, act_vec, exp);
            end
        end
    endtask

    task automatic test_bubble();
        rand_alu(1'b0);
        in_valid = 0;
        in_md_op = 2'b01;
        @(posedge clk);
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL bubble_stall got=%b exp=0", stall); end
        @(negedge clk); #1;
        total++;
        if ({out_valid, out_wb, out_mem} !== {1'b0, 2'b00, 3'b010}) begin
            bad++; $display("FAIL bubble_ctrl got=%b exp=%b", {out_valid, out_wb, out_mem}, 6'b000010);
        end
        clear_inputs();
    endtask

    task automatic test_md_directed();
        run_md("mul_ovf", 2'b01, 32'h0001_0000, 32'h0001_0000);
        clear_inputs();
        @(negedge clk); #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL single_pulse got=%b exp=0", out_valid); end
        run_md("divu", 2'b10, 32'd100, 32'd7);
        run_md("remu", 2'b11, 32'd100, 32'd7);
        run_md("divu0", 2'b10, 32'd5, 32'd0);
        run_md("remu0", 2'b11, 32'd5, 32'd0);
        clear_inputs();
        @(negedge clk); #1;
    endtask

    task automatic test_md_random(input int iters);
        logic [DW-1:0] a, b;
        for (int i = 0; i < iters; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 300));
                default: b = $urandom;
            endcase
            run_md($sformatf("md_rand%0d", i), 2'($urandom_range(1, 3)), a, b);
            clear_inputs();
            @(negedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        run_md("b2b_first", 2'b01, 32'd1234, 32'd5678);
        run_md("b2b_second", 2'b10, 32'hFFFF_FFF0, 32'd3);
        clear_inputs();
        @(negedge clk); #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_tail got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid();
        logic [107:0] exp;
        clear_inputs();
        in_valid = 1; in_md_op = 2'b01; in_rega = 32'd3; in_regb = 32'd4; in_wb = 2'b11;
        // entry edge loads cnt=DW; 22 further BUSY edges bring it to 10
        repeat (23) @(negedge clk);
        #1;
        in_valid = 0; in_md_op = 0;
        rst_n = 0;
        #1;
        total++;
        if (act_vec !== RST_VEC) begin bad++; $display("FAIL midrst_outputs got=%h exp=%h", act_vec, RST_VEC); end
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL midrst_stall got=%b exp=0", stall); end
        @(posedge clk);
        rst_n = 1;
        rand_alu(1'b0);
        in_alu_sel = 0;
        exp = exp_alu_vec();
        #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL midrst_add_stall got=%b exp=0", stall); end
        @(negedge clk); #1;
        total++;
        if (act_vec !== exp) begin bad++; $display("FAIL midrst_add got=%h exp=%h", act_vec, exp); end
        clear_inputs();
        @(negedge clk); #1;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_no_result got=%b exp=0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_forward_directed();
        test_alu_random(1'b0, 40);
        test_alu_random(1'b1, 40);
        test_bubble();
        test_md_directed();
        test_md_random(8);
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
